arbiter_grant_lock: RTL and testbench

//  Sequential grant-holding stage wrapped around the 4-bit fixed-priority Arbiter4.

---
 rtl/arbiter_grant_lock_pkg.sv | 28 ++
 rtl/arbiter_grant_lock_if.sv | 27 ++
 rtl/arbiter_grant_lock.sv | 119 +++++++++++
 tb/tb_arbiter_grant_lock.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arbiter_grant_lock_pkg.sv
// rtl/arbiter_grant_lock_pkg.sv - shared types and helpers for the grant-lock stage
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } state_e;

  // True when exactly one requester bit is set.
  function automatic logic is_onehot(input logic [0:N_REQ-1] v);
    return $onehot(v);
  endfunction

  // Index of the set bit; bit 0 is the highest-priority requester.
  function automatic logic [IDX_W-1:0] onehot2idx(input logic [0:N_REQ-1] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_grant_lock_if.sv
// rtl/arbiter_grant_lock_if.sv - request/grant bundle between requesters, arbiter and lock stage
interface arbiter_grant_lock_if;
  import arb_pkg::*;

  logic [0:N_REQ-1] r;
  logic [0:N_REQ-1] done;
  logic [0:N_REQ-1] r_arb;
  logic [0:N_REQ-1] arb_g;
  logic [0:N_REQ-1] g;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic             timeout;
  logic             err;

  // Requester / external arbiter side.
  modport master (
    output r, done, arb_g,
    input  r_arb, g, owner, busy, timeout, err
  );

  // Grant-lock stage side.
  modport slave (
    input  r, done, arb_g,
    output r_arb, g, owner, busy, timeout, err
  );

endinterface

// File: rtl/arbiter_grant_lock.sv
// rtl/arbiter_grant_lock.sv - registers and locks the Arbiter4 grant with timeout and anti-starvation mask
module arbiter_grant_lock
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  arbiter_grant_lock_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [0:N_REQ-1] g_q, g_d;
  logic [0:N_REQ-1] mask_q, mask_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;

  logic             owner_req;
  logic             owner_done;

  // The previous timed-out owner is hidden from the arbiter while others wait.
  assign bus.r_arb = bus.r & ~mask_q;

  assign owner_req  = bus.r[owner_q];
  assign owner_done = bus.done[owner_q];

  // Next-state logic: grant capture, hold/release decisions and mask upkeep.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    timeout_d = 1'b0;
    err_d     = 1'b0;

    // Nobody else is waiting, so the mask would only starve the masked requester.
    if ((bus.r & ~mask_q) == '0) mask_d = '0;

    case (state_q)
      IDLE: begin
        if (is_onehot(bus.arb_g)) begin
          g_d     = bus.arb_g;
          owner_d = onehot2idx(bus.arb_g);
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = OWNED;
          if (bus.arb_g != mask_q) mask_d = '0;
        end else if (bus.arb_g != '0) begin
          err_d = 1'b1;
        end
      end

      OWNED: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A voluntary release takes precedence over a simultaneous timeout.
        if (!owner_req || owner_done) begin
          g_d     = '0;
          busy_d  = 1'b0;
          owner_d = '0;
          state_d = GAP;
        end else if (cnt_q == HOLD_LAST) begin
          g_d       = '0;
          busy_d    = 1'b0;
          owner_d   = '0;
          timeout_d = 1'b1;
          mask_d    = g_q;
          state_d   = GAP;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      mask_q    <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      mask_q    <= mask_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.g       = g_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_arbiter_grant_lock.sv
// tb/tb_arbiter_grant_lock.sv - directed self-checking bench for arbiter_grant_lock
module tb_arbiter_grant_lock;

  logic       clk = 1'b0;
  logic       reset;
  logic       force_en;
  logic [0:3] force_val;
  int         checks = 0;
  int         failures = 0;

  arbiter_grant_lock_if bus ();

  arbiter_grant_lock #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for Arbiter4: lowest index wins, optionally overridden.
  function automatic logic [0:3] prio(input logic [0:3] v);
    logic [0:3] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && o == '0) o[i] = 1'b1;
    end
    return o;
  endfunction

  always_comb bus.arb_g = force_en ? force_val : prio(bus.r_arb);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.r = 4'b0000; bus.done = 4'b0000; force_en = 1'b0; force_val = 4'b0000;
    tick(); tick();
    checks++; if (bus.g !== 4'b0000) begin failures++; $display("FAIL reset_g got=%b exp=0000", bus.g); end
    checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", bus.timeout, bus.err); end
    bus.r = 4'b1111; #1;
    checks++; if (bus.r_arb !== 4'b1111) begin failures++; $display("FAIL reset_r_arb got=%b exp=1111", bus.r_arb); end
    bus.r = 4'b0000; reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.r = 4'b0100;
    tick();
    checks++; if (bus.g !== 4'b0100) begin failures++; $display("FAIL basic_g got=%b exp=0100", bus.g); end
    checks++; if (bus.owner !== 2'd1) begin failures++; $display("FAIL basic_owner got=%0d exp=1", bus.owner); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    bus.r = 4'b0000;
    tick();
    checks++; if (bus.g !== 4'b0000) begin failures++; $display("FAIL basic_release_g got=%b exp=0000", bus.g); end
    checks++; if (bus.busy !== 1'b0 || bus.owner !== 2'd0) begin failures++; $display("FAIL basic_release_busy_owner got=%b/%0d exp=0/0", bus.busy, bus.owner); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL basic_no_timeout got=%b exp=0", bus.timeout); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.r = 4'b1100;
    tick();
    checks++; if (bus.g !== 4'b1000) begin failures++; $display("FAIL b2b_first_g got=%b exp=1000", bus.g); end
    bus.r = 4'b0100;
    tick();
    checks++; if (bus.g !== 4'b0000) begin failures++; $display("FAIL b2b_release_g got=%b exp=0000", bus.g); end
    tick();
    checks++; if (bus.g !== 4'b0000) begin failures++; $display("FAIL b2b_gap_g got=%b exp=0000", bus.g); end
    tick();
    checks++; if (bus.g !== 4'b0100 || bus.owner !== 2'd1) begin failures++; $display("FAIL b2b_second_g got=%b/%0d exp=0100/1", bus.g, bus.owner); end
    bus.r = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_timeout();
    bus.r = 4'b1000;
    tick();
    checks++; if (bus.g !== 4'b1000) begin failures++; $display("FAIL to_grant got=%b exp=1000", bus.g); end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (bus.g !== 4'b1000 || bus.timeout !== 1'b0) begin failures++; $display("FAIL to_hold_%0d got=%b/%b exp=1000/0", k, bus.g, bus.timeout); end
    end
    tick();
    checks++; if (bus.g !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL to_forced_release got=%b/%b exp=0000/0", bus.g, bus.busy); end
    checks++; if (bus.timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", bus.timeout); end
    checks++; if (bus.r_arb !== 4'b0000) begin failures++; $display("FAIL to_masked got=%b exp=0000", bus.r_arb); end
    bus.r = 4'b1010; #1;
    checks++; if (bus.r_arb !== 4'b0010) begin failures++; $display("FAIL to_masked_other got=%b exp=0010", bus.r_arb); end
    tick();
    checks++; if (bus.timeout !== 1'b0 || bus.g !== 4'b0000) begin failures++; $display("FAIL to_gap got=%b/%b exp=0/0000", bus.timeout, bus.g); end
    tick();
    checks++; if (bus.g !== 4'b0010 || bus.owner !== 2'd2) begin failures++; $display("FAIL to_next_owner got=%b/%0d exp=0010/2", bus.g, bus.owner); end
    checks++; if (bus.r_arb !== 4'b1010) begin failures++; $display("FAIL to_mask_cleared got=%b exp=1010", bus.r_arb); end
  endtask

  task automatic test_done_filter();
    bus.done = 4'b1000;
    tick();
    checks++; if (bus.g !== 4'b0010) begin failures++; $display("FAIL done_ignored got=%b exp=0010", bus.g); end
    bus.done = 4'b0010;
    tick();
    checks++; if (bus.g !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL done_release got=%b/%b exp=0000/0", bus.g, bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL done_no_timeout got=%b exp=0", bus.timeout); end
    bus.done = 4'b0000; bus.r = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_lone_masked();
    bus.r = 4'b1000;
    tick();
    for (int k = 1; k < 8; k++) tick();
    tick();
    checks++; if (bus.timeout !== 1'b1 || bus.r_arb !== 4'b0000) begin failures++; $display("FAIL lone_masked got=%b/%b exp=1/0000", bus.timeout, bus.r_arb); end
    tick();
    checks++; if (bus.r_arb !== 4'b1000 || bus.g !== 4'b0000) begin failures++; $display("FAIL lone_unmask got=%b/%b exp=1000/0000", bus.r_arb, bus.g); end
    tick();
    checks++; if (bus.g !== 4'b1000) begin failures++; $display("FAIL lone_regrant got=%b exp=1000", bus.g); end
    bus.r = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_err();
    force_val = 4'b0110; force_en = 1'b1;
    tick();
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", bus.err); end
    checks++; if (bus.g !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL err_no_grant got=%b/%b exp=0000/0", bus.g, bus.busy); end
    force_en = 1'b0;
    tick();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", bus.err); end
    bus.r = 4'b0100;
    tick();
    checks++; if (bus.g !== 4'b0100) begin failures++; $display("FAIL err_still_idle got=%b exp=0100", bus.g); end
    bus.r = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_release_at_limit();
    bus.r = 4'b0001;
    tick();
    checks++; if (bus.g !== 4'b0001 || bus.owner !== 2'd3) begin failures++; $display("FAIL limit_grant got=%b/%0d exp=0001/3", bus.g, bus.owner); end
    for (int k = 1; k < 8; k++) tick();
    bus.r = 4'b0000;
    tick();
    checks++; if (bus.g !== 4'b0000 || bus.timeout !== 1'b0) begin failures++; $display("FAIL limit_normal_wins got=%b/%b exp=0000/0", bus.g, bus.timeout); end
    bus.r = 4'b0001; #1;
    checks++; if (bus.r_arb !== 4'b0001) begin failures++; $display("FAIL limit_no_mask got=%b exp=0001", bus.r_arb); end
    tick(); tick();
    checks++; if (bus.g !== 4'b0001) begin failures++; $display("FAIL limit_regrant got=%b exp=0001", bus.g); end
  endtask

  task automatic test_reset_mid();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.g !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin failures++; $display("FAIL rst_mid got=%b/%b/%0d exp=0000/0/0", bus.g, bus.busy, bus.owner); end
    checks++; if (bus.r_arb !== 4'b0001) begin failures++; $display("FAIL rst_mid_r_arb got=%b exp=0001", bus.r_arb); end
    reset = 1'b0;
    tick();
    checks++; if (bus.g !== 4'b0001) begin failures++; $display("FAIL rst_mid_idle got=%b exp=0001", bus.g); end
    reset = 1'b1; bus.r = 4'b0000;
    tick();
    reset = 1'b0; bus.r = 4'b1000;
    tick();
    for (int k = 1; k < 8; k++) tick();
    tick();
    bus.r = 4'b1010; #1;
    checks++; if (bus.r_arb !== 4'b0010) begin failures++; $display("FAIL rst_mask_pre got=%b exp=0010", bus.r_arb); end
    reset = 1'b1;
    tick();
    checks++; if (bus.r_arb !== 4'b1010 || bus.g !== 4'b0000) begin failures++; $display("FAIL rst_mask_clear got=%b/%b exp=1010/0000", bus.r_arb, bus.g); end
    reset = 1'b0; bus.r = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_done_filter();
    test_lone_masked();
    test_err();
    test_release_at_limit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
